scanned_display_driver: RTL and testbench
=========================================

# scanned_display_driver

Time-multiplexed driver for a row of DIGITS 15-segment alphanumeric displays. It holds one 4-bit hex code per digit in an internal register file and decodes each code to a 15-bit segment pattern. It scans the digits one at a time, with a one-cycle dead slot between digits to prevent ghosting. It sits between the processor's output port, which writes the digit codes, and the board display pins. It generalises the single-digit combinational decoder to N registered, scanned digits.

## Interface
- DIGITS, 4: number of digits; legal range 2..8.
- PRESCALE, 1000: clock cycles per digit slot; minimum 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for the digit store.
- wr_addr  input  $clog2(DIGITS)  digit index to write; 0 is the least significant digit.
- wr_data  input  4  hex code 0x0–0xF.
- segment_pattern  output  15  registered segment drive, active-high.
- digit_enable  output  DIGITS  registered one-hot digit select, active-high.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

## Operation
- Reset values:
  - store[*]=0, idx=0, cnt=0.
  - segment_pattern=0, digit_enable=0, frame_done=0.
- Write: when wr_en=1 at an edge, store[wr_addr] takes wr_data.
  - If wr_addr ≥ DIGITS, the write is ignored.
  - Writes are accepted every cycle; no handshake or stall.
- Prescaler: cnt counts 0..PRESCALE-1 and wraps to 0. The cycle with cnt==PRESCALE-1 is the tick.
- On a tick edge:
  - idx advances to idx+1, wrapping from DIGITS-1 to 0.
  - digit_enable is set to 0 (dead cycle).
  - segment_pattern is set to pattern(store[next idx]).
  - frame_done is set to 1 only if idx wraps from DIGITS-1 to 0; otherwise 0.
- On a non-tick edge:
  - digit_enable is set to onehot(idx).
  - segment_pattern is set to pattern(store[idx]).
  - frame_done is set to 0.
- Decode table (bit 14 is MSB):
  - 0→0x0C3F, 1→0x0406, 2→0x00DB, 3→0x00CF, 4→0x00E6, 5→0x00ED.
  - 7→0x1401, 8→0x00FF, 9→0x00E7.
  - B→0x128F, C→0x0039, D→0x120F, E→0x00F9, F→0x00F1.
  - 6 and A use the team's standard glyph constants in the package.
  - Blank = 0x0000.
- Write to the displayed digit: a write at edge N is visible on segment_pattern from edge N+1, mid-slot, with no glitch to blank.
- Simultaneous write and tick to the incoming digit: the new data wins, because the decode uses the store's next-state value.
- Reset asserted mid-scan: all state clears immediately (asynchronous). Scanning restarts at digit 0 on the first edge after rst_n rises.

## Timing
- Each slot is PRESCALE cycles: digit enabled for PRESCALE-1 cycles, then 1 dead cycle.
- Frame period = DIGITS×PRESCALE cycles.
- First edge after reset release: digit_enable=onehot(0), segment_pattern=0x0C3F.
- Write-to-pin latency is 1 cycle for the digit currently displayed.
- frame_done rises on the same edge that starts the dead cycle before digit 0.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: digit i>0 shows blank when store[i]==0 and all higher digits are also 0. Digit 0 always shows its code. Blanking is evaluated in the same cycle as the decode, so there is no extra latency.
  - Undefined: every digit shows its decoded code, including leading zeros.

## Structure
- Package display_pkg holds:
  - SEG_W=15.
  - SEG_BLANK.
  - The 16 glyph constants SEG_0..SEG_F.
  - The decode function.
- Sub-module hex_segment_decoder: purely combinational, 4-bit code in, 15-bit pattern out, uses the package constants.
- scanned_display_driver instantiates one hex_segment_decoder on the muxed store output.

## Test plan
- Reset check, DIGITS=4, PRESCALE=4: hold rst_n=0 → all outputs 0. Release → first edge gives digit_enable=0001, segment_pattern=0x0C3F. frame_done first pulses 16 cycles later.
- Scan order: load store = {3,2,1,0} (digit 3..0) → enables cycle 0001, 0010, 0100, 1000 with patterns 0x0C3F, 0x0406, 0x00DB, 0x00CF. Each enable is high 3 cycles, followed by 1 all-zero cycle.
- Mid-slot write: while digit 1 is enabled, write addr1=8 → segment_pattern becomes 0x00FF on the next edge and digit_enable is unchanged.
- Write during tick to the incoming digit: write addr2=F on the tick edge before digit 2 → digit 2 slot shows 0x00F1 from its first cycle.
- Leading-zero blanking with the macro defined: store={0,0,0,5} → digits 3 and 2 show 0x0000, digit 1 shows 0x0000, digit 0 shows 0x00ED. Without the macro: 0x0C3F, 0x0C3F, 0x0C3F, 0x00ED.
- Asynchronous reset mid-slot: drop rst_n asynchronously while digit 2 is enabled → outputs clear before the next edge. After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the scanned display: segment width, blank pattern,
// the sixteen hex glyphs for a 15-segment digit, and the code-to-glyph decode.
package display_pkg;

    localparam int SEG_W = 15;

    localparam logic [SEG_W-1:0] SEG_BLANK = 15'h0000;

    localparam logic [SEG_W-1:0] SEG_0 = 15'h0C3F;
    localparam logic [SEG_W-1:0] SEG_1 = 15'h0406;
    localparam logic [SEG_W-1:0] SEG_2 = 15'h00DB;
    localparam logic [SEG_W-1:0] SEG_3 = 15'h00CF;
    localparam logic [SEG_W-1:0] SEG_4 = 15'h00E6;
    localparam logic [SEG_W-1:0] SEG_5 = 15'h00ED;
    localparam logic [SEG_W-1:0] SEG_6 = 15'h00FD;
    localparam logic [SEG_W-1:0] SEG_7 = 15'h1401;
    localparam logic [SEG_W-1:0] SEG_8 = 15'h00FF;
    localparam logic [SEG_W-1:0] SEG_9 = 15'h00E7;
    localparam logic [SEG_W-1:0] SEG_A = 15'h00F7;
    localparam logic [SEG_W-1:0] SEG_B = 15'h128F;
    localparam logic [SEG_W-1:0] SEG_C = 15'h0039;
    localparam logic [SEG_W-1:0] SEG_D = 15'h120F;
    localparam logic [SEG_W-1:0] SEG_E = 15'h00F9;
    localparam logic [SEG_W-1:0] SEG_F = 15'h00F1;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] code);
        logic [SEG_W-1:0] seg;
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_segment_decoder.sv
// Combinational 4-bit hex code to 15-segment glyph decoder.
module hex_segment_decoder
    import display_pkg::*;
(
    input  logic [3:0]       code,
    output logic [SEG_W-1:0] seg
);

    // Table lookup of the glyph for the selected code
    always_comb begin
        seg = hex_to_seg(code);
    end

endmodule

// File: rtl/scanned_display_driver.sv
// Time-multiplexed driver for DIGITS 15-segment digits. Holds one hex code per
// digit, scans them one slot at a time with a dead cycle between digits, and
// pulses frame_done when the scan wraps back to digit 0.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shows its code).
//
// Decode always looks at the store's next-state value so that a write landing
// on the same edge as the output update is shown immediately.
module scanned_display_driver
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    output logic [SEG_W-1:0]          segment_pattern,
    output logic [DIGITS-1:0]         digit_enable,
    output logic                      frame_done
);

    localparam int AW = $clog2(DIGITS);
    localparam int CW = $clog2(PRESCALE);

    logic [3:0]       store      [DIGITS];
    logic [3:0]       store_next [DIGITS];
    logic [AW-1:0]    idx;
    logic [AW-1:0]    idx_next;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic             idx_wrap;
    logic [3:0]       code_sel;
    logic [SEG_W-1:0] dec_seg;
    logic [SEG_W-1:0] pattern_next;

    assign tick     = (cnt == CW'(PRESCALE - 1));
    assign idx_wrap = (idx == AW'(DIGITS - 1));

    // Store contents after this edge's write; out-of-range addresses match no digit
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            store_next[i] = store[i];
            if (wr_en && (wr_addr == AW'(i))) begin
                store_next[i] = wr_data;
            end
        end
    end

    // Digit that will be selected after this edge
    always_comb begin
        idx_next = idx;
        if (tick) begin
            idx_next = idx_wrap ? '0 : idx + 1'b1;
        end
    end

    // Mux the code for the selected digit into the shared decoder
    always_comb begin
        code_sel = store_next[idx_next];
    end

    hex_segment_decoder u_dec (
        .code (code_sel),
        .seg  (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_blank;

    // Blank a non-zero-index digit when it and every digit above it are zero
    always_comb begin
        lz_blank = (idx_next != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx_next)) && (store_next[i] != 4'h0)) begin
                lz_blank = 1'b0;
            end
        end
    end

    // Apply blanking on top of the decoded glyph
    always_comb begin
        pattern_next = lz_blank ? SEG_BLANK : dec_seg;
    end
`else
    // Every digit shows its decoded glyph, leading zeros included
    always_comb begin
        pattern_next = dec_seg;
    end
`endif

    // Digit code register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                store[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                store[i] <= store_next[i];
            end
        end
    end

    // Slot prescaler and scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            idx <= idx_next;
        end
    end

    // Registered pin drive: dead cycle on the tick, otherwise the active digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segment_pattern <= SEG_BLANK;
            digit_enable    <= '0;
            frame_done      <= 1'b0;
        end else begin
            segment_pattern <= pattern_next;
            if (tick) begin
                digit_enable <= '0;
                frame_done   <= idx_wrap;
            end else begin
                digit_enable <= DIGITS'(1) << idx;
                frame_done   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scanned_display_driver.sv
// Scoreboard bench for scanned_display_driver with DIGITS=4, PRESCALE=4.
module tb_scanned_display_driver;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;

    localparam logic [14:0] GLYPH [16] = '{
        15'h0C3F, 15'h0406, 15'h00DB, 15'h00CF, 15'h00E6, 15'h00ED, 15'h00FD, 15'h1401,
        15'h00FF, 15'h00E7, 15'h00F7, 15'h128F, 15'h0039, 15'h120F, 15'h00F9, 15'h00F1
    };

    typedef struct packed {
        logic [14:0] seg;
        logic [3:0]  en;
        logic        fd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [14:0] segment_pattern;
    logic [3:0]  digit_enable;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    exp_t q[$];

    logic [3:0] m_store [4];
    logic [3:0] m_ns    [4];
    int         m_idx;
    int         m_cnt;

    scanned_display_driver #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .segment_pattern (segment_pattern),
        .digit_enable    (digit_enable),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] model_pat(input int i);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = i; j < 4; j++) begin
            if (m_ns[j] != 4'h0) all_zero = 1'b0;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && all_zero) return 15'h0000;
`endif
        return GLYPH[m_ns[i]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_store[i] = 4'h0;
        m_idx = 0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, predict the outputs, push, clock, pop and compare.
    task automatic step(input logic we, input logic [1:0] a, input logic [3:0] d);
        exp_t e;
        int   nidx;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 4; i++) m_ns[i] = m_store[i];
        if (we) m_ns[a] = d;
        if (m_cnt == PRESCALE - 1) begin
            nidx  = (m_idx + 1) % DIGITS;
            e.en  = 4'b0000;
            e.seg = model_pat(nidx);
            e.fd  = (m_idx == DIGITS - 1);
            m_cnt = 0;
        end else begin
            nidx  = m_idx;
            e.en  = 4'(1 << m_idx);
            e.seg = model_pat(m_idx);
            e.fd  = 1'b0;
            m_cnt = m_cnt + 1;
        end
        m_idx = nidx;
        for (int i = 0; i < 4; i++) m_store[i] = m_ns[i];
        q.push_back(e);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("sb_seg", 32'(segment_pattern), 32'(e.seg));
            chk("sb_en",  32'(digit_enable),    32'(e.en));
            chk("sb_fd",  32'(frame_done),      32'(e.fd));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'h0);
    endtask

    // Advance until the model sits at the given index and prescale count.
    task automatic seek(input int want_idx, input int want_cnt);
        int guard;
        guard = 0;
        while (!(m_idx == want_idx && m_cnt == want_cnt) && guard < 32) begin
            step(1'b0, 2'd0, 4'h0);
            guard++;
        end
        if (guard >= 32) chk("seek_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 4'h0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(segment_pattern), 32'h0);
        chk("rst_en",  32'(digit_enable),    32'h0);
        chk("rst_fd",  32'(frame_done),      32'h0);
        rst_n = 1'b1;

        // First edge after release shows digit 0 with code 0
        step(1'b0, 2'd0, 4'h0);
        chk("first_seg", 32'(segment_pattern), 32'h0C3F);
        chk("first_en",  32'(digit_enable),    32'h1);
        for (int i = 2; i <= 16; i++) begin
            step(1'b0, 2'd0, 4'h0);
            if (i < 16) chk("early_fd", 32'(frame_done), 32'h0);
        end
        chk("frame_fd16", 32'(frame_done), 32'h1);

        // Scan order with store = {3,2,1,0}
        step(1'b1, 2'd0, 4'h0);
        step(1'b1, 2'd1, 4'h1);
        step(1'b1, 2'd2, 4'h2);
        step(1'b1, 2'd3, 4'h3);
        seek(0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'd0, 4'h0);
            if (digit_enable == 4'b0100) chk("scan_d2", 32'(segment_pattern), 32'h00DB);
            if (digit_enable == 4'b1000) chk("scan_d3", 32'(segment_pattern), 32'h00CF);
        end

        // Mid-slot write to the displayed digit
        seek(1, 1);
        step(1'b1, 2'd1, 4'h8);
        chk("mid_seg", 32'(segment_pattern), 32'h00FF);
        chk("mid_en",  32'(digit_enable),    32'h2);

        // Write landing on the tick into digit 2
        seek(1, 3);
        step(1'b1, 2'd2, 4'hF);
        chk("tickwr_seg0", 32'(segment_pattern), 32'h00F1);
        chk("tickwr_en0",  32'(digit_enable),    32'h0);
        step(1'b0, 2'd0, 4'h0);
        chk("tickwr_seg1", 32'(segment_pattern), 32'h00F1);
        chk("tickwr_en1",  32'(digit_enable),    32'h4);

        // Leading-zero case: store = {0,0,0,5}
        step(1'b1, 2'd1, 4'h0);
        step(1'b1, 2'd2, 4'h0);
        step(1'b1, 2'd3, 4'h0);
        step(1'b1, 2'd0, 4'h5);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'd0, 4'h0);
            if (digit_enable == 4'b0001) chk("lz_d0", 32'(segment_pattern), 32'h00ED);
`ifdef LEADING_ZERO_BLANK_EN
            if (digit_enable > 4'b0001) chk("lz_hi", 32'(segment_pattern), 32'h0000);
`else
            if (digit_enable > 4'b0001) chk("lz_hi", 32'(segment_pattern), 32'h0C3F);
`endif
        end

        // Random writes exercise every glyph through the scoreboard
        for (int i = 0; i < 96; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset while digit 2 is enabled
        seek(2, 1);
        chk("pre_rst_en", 32'(digit_enable), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(segment_pattern), 32'h0);
        chk("arst_en",  32'(digit_enable),    32'h0);
        chk("arst_fd",  32'(frame_done),      32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 2'd0, 4'h0);
        chk("restart_en",  32'(digit_enable),    32'h1);
        chk("restart_seg", 32'(segment_pattern), 32'h0C3F);
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
